// File: rtl/axis_in_buffer.sv
// Double-buffered AXI-Stream frame capture: one bank fills from the stream while
// the other is held for a consumer, with the banks swapping roles as frames close.
module axis_in_buffer #(
  parameter  int INW      = 24,
  parameter  int DEPTH    = 19,
  localparam int LOGDEPTH = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [INW-1:0]      IN_AXIS_TDATA,
  input  logic                IN_AXIS_TVALID,
  input  logic                IN_AXIS_TLAST,
  output logic                IN_AXIS_TREADY,
  output logic                loaded,
  input  logic [LOGDEPTH-1:0] rd_addr,
  output logic [INW-1:0]      rd_data,
  output logic [LOGDEPTH:0]   rd_len,
  output logic                rd_truncated,
  input  logic                compute_done
);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_state_t;

  logic [INW-1:0]      mem [2][DEPTH];
  bank_state_t         state   [2];
  bank_state_t         state_n [2];
  logic [LOGDEPTH:0]   len     [2];
  logic [LOGDEPTH:0]   len_n   [2];
  logic [1:0]          trunc, trunc_n;
  logic                wr_bank, wr_bank_n;
  logic                rd_bank, rd_bank_n;
  logic [LOGDEPTH-1:0] wr_cnt, wr_cnt_n;

  logic hs, close, done_ok;

  assign IN_AXIS_TREADY = (state[wr_bank] != FULL);
  assign loaded         = (state[rd_bank] == FULL);
  assign rd_len         = len[rd_bank];
  assign rd_truncated   = trunc[rd_bank];

  assign hs      = IN_AXIS_TVALID && IN_AXIS_TREADY;
  assign close   = hs && (IN_AXIS_TLAST || (wr_cnt == LOGDEPTH'(DEPTH - 1)));
  assign done_ok = compute_done && loaded;

  // A close always targets a non-FULL bank and a release a FULL one, so the
  // two updates below never touch the same bank.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      state_n[b] = state[b];
      len_n[b]   = len[b];
    end
    trunc_n   = trunc;
    wr_bank_n = wr_bank;
    rd_bank_n = rd_bank;
    wr_cnt_n  = wr_cnt;
    if (hs) begin
      state_n[wr_bank] = FILLING;
      wr_cnt_n         = wr_cnt + LOGDEPTH'(1);
      if (close) begin
        state_n[wr_bank] = FULL;
        len_n[wr_bank]   = IN_AXIS_TLAST ? ((LOGDEPTH+1)'(wr_cnt) + (LOGDEPTH+1)'(1))
                                         : (LOGDEPTH+1)'(DEPTH);
        trunc_n[wr_bank] = !IN_AXIS_TLAST;
        wr_cnt_n         = '0;
        wr_bank_n        = !wr_bank;
      end
    end
    if (done_ok) begin
      state_n[rd_bank] = EMPTY;
      rd_bank_n        = !rd_bank;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        state[b] <= EMPTY;
        len[b]   <= '0;
      end
      trunc   <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        state[b] <= state_n[b];
        len[b]   <= len_n[b];
      end
      trunc   <= trunc_n;
      wr_bank <= wr_bank_n;
      rd_bank <= rd_bank_n;
      wr_cnt  <= wr_cnt_n;
    end
  end

  // Storage and read port carry no reset; contents are qualified by bank state.
  always_ff @(posedge clk) begin
    if (hs) mem[wr_bank][wr_cnt] <= IN_AXIS_TDATA;
    rd_data <= mem[rd_bank][rd_addr];
  end

endmodule

// File: tb/tb_axis_in_buffer.sv
// Directed bench for axis_in_buffer: a frame-level model fills a scoreboard as
// words are sent, and each delivered frame is checked against it in order.
module tb_axis_in_buffer;
  localparam int INW      = 24;
  localparam int DEPTH    = 19;
  localparam int LOGDEPTH = $clog2(DEPTH);

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [INW-1:0]      IN_AXIS_TDATA = '0;
  logic                IN_AXIS_TVALID = 1'b0;
  logic                IN_AXIS_TLAST = 1'b0;
  logic                IN_AXIS_TREADY;
  logic                loaded;
  logic [LOGDEPTH-1:0] rd_addr = '0;
  logic [INW-1:0]      rd_data;
  logic [LOGDEPTH:0]   rd_len;
  logic                rd_truncated;
  logic                compute_done = 1'b0;

  int tests = 0;
  int fails = 0;

  int unsigned cur_words [$];
  int unsigned exp_words [$];
  int unsigned exp_len   [$];
  int unsigned exp_trunc [$];
  int          cnt = 0;

  axis_in_buffer #(.INW(INW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .IN_AXIS_TDATA(IN_AXIS_TDATA), .IN_AXIS_TVALID(IN_AXIS_TVALID),
    .IN_AXIS_TLAST(IN_AXIS_TLAST), .IN_AXIS_TREADY(IN_AXIS_TREADY),
    .loaded(loaded), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_len(rd_len), .rd_truncated(rd_truncated), .compute_done(compute_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    cur_words.delete();
    exp_words.delete();
    exp_len.delete();
    exp_trunc.delete();
    cnt = 0;
  endtask

  // One-cycle reset pulse, then the post-reset outputs are checked.
  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_clear();
    chk("rst_tready", IN_AXIS_TREADY, 1);
    chk("rst_loaded", loaded, 0);
    chk("rst_rd_len", rd_len, 0);
    chk("rst_rd_trunc", rd_truncated, 0);
  endtask

  task automatic send(input int unsigned data, input bit last, input bit with_done);
    IN_AXIS_TDATA  = INW'(data);
    IN_AXIS_TLAST  = last;
    IN_AXIS_TVALID = 1'b1;
    compute_done   = with_done;
    chk("tready_before_send", IN_AXIS_TREADY, 1);
    cur_words.push_back(data);
    cnt++;
    if (last || cnt == DEPTH) begin
      exp_len.push_back(cnt);
      exp_trunc.push_back(last ? 0 : 1);
      foreach (cur_words[i]) exp_words.push_back(cur_words[i]);
      cur_words.delete();
      cnt = 0;
    end
    tick();
    IN_AXIS_TVALID = 1'b0;
    IN_AXIS_TLAST  = 1'b0;
    compute_done   = 1'b0;
  endtask

  // Checks the read bank against the oldest closed frame and reads every word.
  task automatic verify_frame();
    int unsigned n;
    int unsigned w;
    chk("loaded", loaded, 1);
    chk("sb_has_frame", exp_len.size() != 0, 1);
    if (exp_len.size() == 0) return;
    n = exp_len.pop_front();
    chk("rd_len", rd_len, n);
    chk("rd_trunc", rd_truncated, exp_trunc.pop_front());
    for (int i = 0; i < int'(n); i++) begin
      rd_addr = LOGDEPTH'(i);
      tick();
      w = exp_words.pop_front();
      chk("rd_data", rd_data, w);
    end
  endtask

  task automatic pulse_done();
    compute_done = 1'b1;
    tick();
    compute_done = 1'b0;
  endtask

  task automatic consume();
    verify_frame();
    pulse_done();
  endtask

  initial begin
    tick();
    do_reset();

    // Single frame 10,20,30,40
    send(10, 0, 0); send(20, 0, 0); send(30, 0, 0);
    chk("single_not_loaded_early", loaded, 0);
    send(40, 1, 0);
    chk("single_loaded_next", loaded, 1);
    chk("single_rd_len", rd_len, 4);
    chk("single_trunc", rd_truncated, 0);
    rd_addr = LOGDEPTH'(2);
    tick();
    chk("single_addr2", rd_data, 30);
    consume();
    chk("single_released", loaded, 0);
    chk("single_tready", IN_AXIS_TREADY, 1);

    // Back-to-back frames fill both banks and stall the stream
    for (int i = 0; i < 3; i++) send(100 + i, i == 2, 0);
    for (int i = 0; i < 5; i++) send(200 + i, i == 4, 0);
    chk("b2b_stall", IN_AXIS_TREADY, 0);
    chk("b2b_loaded", loaded, 1);
    consume();
    chk("b2b_still_loaded", loaded, 1);
    chk("b2b_len_b", rd_len, 5);
    chk("b2b_tready", IN_AXIS_TREADY, 1);
    consume();
    chk("b2b_empty", loaded, 0);

    // Overflow: 19 words without TLAST, then word 20 starts a new frame
    do_reset();
    for (int i = 1; i <= DEPTH; i++) send(i, 0, 0);
    chk("ovf_loaded", loaded, 1);
    chk("ovf_len", rd_len, DEPTH);
    chk("ovf_trunc", rd_truncated, 1);
    chk("ovf_tready", IN_AXIS_TREADY, 1);
    send(20, 1, 0);
    chk("ovf_both_full", IN_AXIS_TREADY, 0);
    consume();
    chk("ovf_next_len", rd_len, 1);
    consume();

    // Exactly DEPTH words with TLAST on the last one is not truncated
    for (int i = 0; i < DEPTH; i++) send(300 + i, i == DEPTH - 1, 0);
    chk("full_tlast_trunc", rd_truncated, 0);
    consume();

    // Frame close and compute_done on the same edge
    send(500, 0, 0); send(501, 1, 0);
    send(600, 0, 0);
    verify_frame();
    send(601, 1, 1);
    chk("simul_loaded", loaded, 1);
    chk("simul_len", rd_len, 2);
    chk("simul_tready", IN_AXIS_TREADY, 1);
    consume();

    // Reset mid-frame discards the partial frame
    send(900, 0, 0); send(901, 0, 0);
    do_reset();
    send(7, 1, 0);
    chk("midrst_len", rd_len, 1);
    consume();

    // Spurious compute_done with nothing loaded
    for (int i = 0; i < 5; i++) begin
      compute_done = 1'b1;
      tick();
      chk("spur_loaded", loaded, 0);
      chk("spur_tready", IN_AXIS_TREADY, 1);
    end
    compute_done = 1'b0;
    send(41, 0, 0); send(42, 1, 0);
    consume();
    chk("spur_final_empty", loaded, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end
endmodule
